// File: rtl/mipi_loopback_ctrl_if.sv
// RX pixel stream in, gated TX pixel stream out, for the MIPI loopback sequencer.
// There is no backpressure: an RX beat is taken on every cycle rx_valid is high, and TX must accept every beat.
interface mipi_loopback_ctrl_if;
    logic        rx_valid;
    logic        rx_hsync;
    logic        rx_vsync;
    logic [63:0] rx_data;
    logic [17:0] rx_error;
    logic        tx_valid;
    logic        tx_hsync;
    logic        tx_vsync;
    logic [63:0] tx_data;

    modport slave (
        input  rx_valid, rx_hsync, rx_vsync, rx_data, rx_error,
        output tx_valid, tx_hsync, tx_vsync, tx_data
    );

    modport master (
        output rx_valid, rx_hsync, rx_vsync, rx_data, rx_error,
        input  tx_valid, tx_hsync, tx_vsync, tx_data
    );
endinterface

// File: rtl/mipi_loopback_ctrl.sv
// MIPI RX->TX loopback sequencer: ordered reset release, frame-aligned forwarding, 2-cycle pipe.
// Define MIPI_LB_ERR_RECOVERY_EN to enable per-frame error counting and the RECOVER state.
module mipi_loopback_ctrl #(
    parameter int PHY_RST_CYCLES  = 64,
    parameter int CORE_RST_CYCLES = 16,
`ifdef MIPI_LB_ERR_RECOVERY_EN
    parameter int ERR_THRESH      = 4,
`endif
    parameter int CLEAR_CYCLES    = 8
) (
    input  logic                 rx_pixel_clk,
    input  logic                 rst,
    input  logic                 enable,
    mipi_loopback_ctrl_if.slave  bus,
    output logic                 tx_dphy_rstn,
    output logic                 tx_rstn,
    output logic                 rx_dphy_rstn,
    output logic                 rx_rstn,
    output logic                 rx_clear,
    output logic [2:0]           state,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt,
    output logic                 led_run
);

    typedef enum logic [2:0] {
        RST_PHY    = 3'd0,
        RST_CORE   = 3'd1,
        WAIT_FRAME = 3'd2,
        RUN        = 3'd3,
        RECOVER    = 3'd4
    } state_t;

    localparam logic [15:0] PHY_LAST   = 16'(PHY_RST_CYCLES - 1);
    localparam logic [15:0] CORE_LAST  = 16'(CORE_RST_CYCLES - 1);
    localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic        vsync_q;
    logic        vs_rise;
    logic        err_any;
    logic        err_trip;
    logic        fwd;
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;
    logic        dphy_rstn_q;
    logic        core_rstn_q;
    logic        led_run_q;

    logic        valid_s1, hsync_s1, vsync_s1, fwd_s1;
    logic [63:0] data_s1;
    logic        valid_s2, hsync_s2, vsync_s2, fwd_s2;
    logic [63:0] data_s2;

    assign vs_rise = bus.rx_vsync & ~vsync_q;
    assign err_any = |bus.rx_error;

`ifdef MIPI_LB_ERR_RECOVERY_EN
    logic [7:0] frame_err_q, frame_err_d;
    logic       rx_clear_q;

    // Counts only inside RUN; held at zero elsewhere so every new RUN starts clean.
    always_comb begin
        frame_err_d = 8'd0;
        if (state_q == RUN) begin
            frame_err_d = vs_rise ? 8'd0 : frame_err_q;
            if (err_any && frame_err_d != 8'hff) begin
                frame_err_d = frame_err_d + 8'd1;
            end
        end
    end

    assign err_trip = (state_q == RUN) && err_any && (frame_err_d == 8'(ERR_THRESH));

    always_ff @(posedge rx_pixel_clk) begin
        if (rst) begin
            frame_err_q <= 8'd0;
            rx_clear_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            rx_clear_q  <= (state_d == RECOVER);
        end
    end

    assign rx_clear = rx_clear_q;
`else
    assign err_trip = 1'b0;
    assign rx_clear = 1'b0;
`endif

    // Next state and forwarding decision for the beat presented this cycle.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 16'd1;
        fwd     = 1'b0;
        unique case (state_q)
            RST_PHY: begin
                if (tmr_q == PHY_LAST) begin
                    state_d = RST_CORE;
                    tmr_d   = 16'd0;
                end
            end
            RST_CORE: begin
                if (tmr_q == CORE_LAST) begin
                    state_d = WAIT_FRAME;
                    tmr_d   = 16'd0;
                end
            end
            WAIT_FRAME: begin
                tmr_d = 16'd0;
                if (vs_rise && enable) begin
                    state_d = RUN;
                    fwd     = 1'b1;
                end
            end
            RUN: begin
                tmr_d = 16'd0;
                if (err_trip) begin
                    state_d = RECOVER;
                end else if (vs_rise && !enable) begin
                    state_d = WAIT_FRAME;
                end else begin
                    fwd = 1'b1;
                end
            end
            RECOVER: begin
                if (tmr_q == CLEAR_LAST) begin
                    state_d = WAIT_FRAME;
                    tmr_d   = 16'd0;
                end
            end
            default: begin
                state_d = RST_PHY;
                tmr_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge rx_pixel_clk) begin
        if (rst) begin
            state_q     <= RST_PHY;
            tmr_q       <= 16'd0;
            vsync_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 8'd0;
            dphy_rstn_q <= 1'b0;
            core_rstn_q <= 1'b0;
            led_run_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            vsync_q     <= bus.rx_vsync;
            if (fwd && vs_rise) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (err_any && err_cnt_q != 8'hff) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            // Registered from the next state so reset lines into the PHYs never glitch.
            dphy_rstn_q <= (state_d != RST_PHY);
            core_rstn_q <= (state_d != RST_PHY) && (state_d != RST_CORE);
            led_run_q   <= (state_d == RUN);
        end
    end

    always_ff @(posedge rx_pixel_clk) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            hsync_s1 <= 1'b0;
            vsync_s1 <= 1'b0;
            fwd_s1   <= 1'b0;
            data_s1  <= 64'd0;
            valid_s2 <= 1'b0;
            hsync_s2 <= 1'b0;
            vsync_s2 <= 1'b0;
            fwd_s2   <= 1'b0;
            data_s2  <= 64'd0;
        end else begin
            valid_s1 <= bus.rx_valid;
            hsync_s1 <= bus.rx_hsync;
            vsync_s1 <= bus.rx_vsync;
            fwd_s1   <= fwd;
            data_s1  <= bus.rx_data;
            valid_s2 <= valid_s1;
            hsync_s2 <= hsync_s1;
            vsync_s2 <= vsync_s1;
            fwd_s2   <= fwd_s1;
            data_s2  <= data_s1;
        end
    end

    assign bus.tx_valid = valid_s2 & fwd_s2;
    assign bus.tx_hsync = hsync_s2 & fwd_s2;
    assign bus.tx_vsync = vsync_s2 & fwd_s2;
    assign bus.tx_data  = data_s2;

    assign tx_dphy_rstn = dphy_rstn_q;
    assign rx_dphy_rstn = dphy_rstn_q;
    assign tx_rstn      = core_rstn_q;
    assign rx_rstn      = core_rstn_q;
    assign state        = state_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign led_run      = led_run_q;

endmodule

// File: doc/mipi_loopback_ctrl.md
# mipi_loopback_ctrl

Sequencer for the MIPI RX→TX loopback path, clocked in the RX pixel domain. It releases the D-PHY and core resets of both MIPI instances in order, then waits for a clean frame start. It forwards RX beats to TX only on whole-frame boundaries, with a fixed 2-cycle pipeline. On excessive RX errors it clears the RX core and re-acquires frame sync.

## Interface
- PHY_RST_CYCLES, 64: cycles all resets are held low after `rst`.
- CORE_RST_CYCLES, 16: cycles the core resets stay low after the D-PHY resets release.
- CLEAR_CYCLES, 8: width of the `rx_clear` pulse in RECOVER.
- ERR_THRESH, 4: error cycles within one frame that trigger RECOVER.

Ports (one clock; reset is synchronous and active-high):
- rx_pixel_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  forwarding request; sampled only at frame boundaries.
- rx_valid  in  1  RX pixel valid.
- rx_hsync  in  1  RX line sync (lane 0).
- rx_vsync  in  1  RX frame sync (lane 0).
- rx_data  in  64  RX pixel data.
- rx_error  in  18  RX error flags; any bit set counts as one error cycle.
- tx_dphy_rstn, tx_rstn, rx_dphy_rstn, rx_rstn  out  1 each  MIPI reset controls, active low.
- rx_clear  out  1  RX clear pulse.
- tx_valid, tx_hsync, tx_vsync  out  1 each  gated, delayed RX syncs.
- tx_data  out  64  delayed `rx_data`.
- state  out  3  current state encoding: RST_PHY=0, RST_CORE=1, WAIT_FRAME=2, RUN=3, RECOVER=4.
- frame_cnt  out  16  forwarded frames; wraps at 16 bits.
- err_cnt  out  8  total error cycles since reset; saturates at 255.
- led_run  out  1  high while state is RUN.

## Operation
- `vs_rise = rx_vsync & ~vsync_q`. `vsync_q` is the registered `rx_vsync` and resets to 0.
- **RST_PHY**: all four reset outputs low. After PHY_RST_CYCLES cycles → RST_CORE.
- **RST_CORE**: both `*_dphy_rstn` high, both `*_rstn` low. After CORE_RST_CYCLES cycles → WAIT_FRAME. From here on, all four reset outputs stay high until `rst`.
- **WAIT_FRAME**: nothing is forwarded. On `vs_rise && enable` → RUN; that beat is forwarded and `frame_cnt` increments.
- **RUN**: every beat is forwarded.
  - On `vs_rise`, the per-frame error count clears.
  - If `enable` = 1: `frame_cnt` increments and the state stays RUN.
  - If `enable` = 0: → WAIT_FRAME, and that beat is not forwarded.
- **RECOVER**: `rx_clear` = 1 for exactly CLEAR_CYCLES cycles, then → WAIT_FRAME. Nothing is forwarded.
- Error count:
  - `err_cnt` increments on every cycle with `|rx_error`, in all states.
  - The per-frame count (8-bit, saturating) increments only in RUN.
- Simultaneous `vs_rise` and an error cycle in RUN: the per-frame count is cleared, then loaded with 1.
- `fwd` = the state decode for the beat, as defined above.

## Timing
- Stage 1 registers `rx_valid`, `rx_hsync`, `rx_vsync`, `rx_data` and `fwd`. Stage 2 produces the outputs:
  - `tx_valid = valid_s2 & fwd_s2`
  - `tx_hsync = hsync_s2 & fwd_s2`
  - `tx_vsync = vsync_s2 & fwd_s2`
  - `tx_data = data_s2`, ungated.
- Latency from RX input to TX output is 2 cycles for valid, syncs and data.
- State-exit timing: if a count is N, the state lasts N cycles and the next state is visible on cycle N+1.
- Reset values:
  - all reset outputs 0
  - `rx_clear`, `tx_*` outputs, `led_run` 0
  - `tx_data` 0
  - counters 0, pipeline registers 0
  - `state` = RST_PHY
- `rst` asserted mid-frame: on the next edge, outputs take reset values and the pipeline flushes. No partial frame reaches TX afterwards.
- `enable` deasserted mid-frame: the current frame completes; gating starts with the next frame's `vs_rise` beat.

## Configuration
- `MIPI_LB_ERR_RECOVERY_EN` defined: RUN → RECOVER on the cycle the per-frame count reaches ERR_THRESH. That beat is not forwarded.
- Not defined:
  - RECOVER is unreachable and `rx_clear` is tied to 0.
  - Errors only update `err_cnt`.
  - The per-frame counter is omitted.

## Test plan
- Release `rst` → all resets low for 64 cycles; D-PHY resets rise on cycle 65; core resets rise on cycle 81; `state` = 2.
- `enable` = 1, vsync pulse at cycle T → `tx_vsync` = 1 at T+2, `frame_cnt` = 1, `tx_data` equals `rx_data` delayed 2 cycles.
- Beats arriving in WAIT_FRAME before any vsync → `tx_valid` stays 0 while `rx_valid` toggles.
- `enable` dropped mid-frame, next vsync at T → `tx_valid` = 0 from T+2 onward; `state` = 2; `frame_cnt` unchanged.
- With the macro defined, 4 error cycles in one frame → `state` = 4, `rx_clear` high for 8 cycles, then `state` = 2 and `err_cnt` = 4.
- `rst` pulsed during RUN → next cycle all outputs at reset values; `tx_valid` = 0 thereafter until a new frame start.
